// File: rtl/cpu_types_pkg.sv
// Shared CPU/RAM types used across the multicore datapath.
package cpu_types_pkg;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

endpackage

// File: rtl/memctrl_pkg.sv
// Coherent memory controller FSM states and block address helper.
package memctrl_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SNOOP  = 3'd1,
      C2C    = 3'd2,
      RAMRD  = 3'd3,
      RAMWR  = 3'd4,
      IFETCH = 3'd5
   } memctrl_state_t;

   // Replace the word-select field (k bits above the byte offset) of addr with word.
   function automatic logic [31:0] WORD_OFFSET(input logic [31:0] addr,
                                               input logic [31:0] word,
                                               input int unsigned k);
      logic [31:0] mask;
      mask = (32'd1 << (k + 32'd2)) - 32'd1;
      return (addr & ~mask) | ((word << 2) & mask);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Picks one requester, searching upward from ptr with wrap; emits one-hot grant and index.
module rr_arbiter #(
   parameter int unsigned CPUS    = 4,
   parameter int unsigned CPUID_W = $clog2(CPUS)
) (
   input  logic [CPUS-1:0]    req,
   input  logic [CPUID_W-1:0] ptr,
   output logic [CPUS-1:0]    grant,
   output logic [CPUID_W-1:0] idx
);

   int unsigned cand;
   logic        found;

   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      cand  = 0;
      for (int unsigned i = 0; i < CPUS; i++) begin
         cand = int'(ptr) + i;
         if (cand >= CPUS) cand = cand - CPUS;
         if (!found && req[CPUID_W'(cand)]) begin
            found                 = 1'b1;
            grant[CPUID_W'(cand)] = 1'b1;
            idx                   = CPUID_W'(cand);
         end
      end
   end

endmodule

// File: rtl/coherent_memory_control.sv
// N-core MSI snooping bus controller onto a single RAM port.
// MEMCTRL_RR_ARB_EN: round-robin within a request class; undefined gives fixed lowest-index priority.
module coherent_memory_control
   import cpu_types_pkg::*;
   import memctrl_pkg::*;
#(
   parameter int unsigned CPUS            = 4,
   parameter int unsigned WORDS_PER_BLOCK = 2,
   parameter int unsigned CPUID_W         = $clog2(CPUS)
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [CPUS-1:0]      iREN,
   input  logic [CPUS-1:0]      dREN,
   input  logic [CPUS-1:0]      dWEN,
   input  logic [CPUS-1:0]      cctrans,
   input  logic [CPUS-1:0]      ccwrite,
   input  logic [CPUS-1:0]      snoophit,
   input  logic [CPUS-1:0][31:0] iaddr,
   input  logic [CPUS-1:0][31:0] daddr,
   input  logic [CPUS-1:0][31:0] dstore,
   output logic [CPUS-1:0]      iwait,
   output logic [CPUS-1:0]      dwait,
   output logic [CPUS-1:0][31:0] iload,
   output logic [CPUS-1:0][31:0] dload,
   output logic [CPUS-1:0]      ccwait,
   output logic [CPUS-1:0]      ccinv,
   output logic [CPUS-1:0][31:0] ccsnoopaddr,
   input  ramstate_t            ramstate,
   input  logic [31:0]          ramload,
   output logic                 ramREN,
   output logic                 ramWEN,
   output logic [31:0]          ramaddr,
   output logic [31:0]          ramstore
);

   localparam int unsigned WORD_K = $clog2(WORDS_PER_BLOCK);
   localparam int unsigned WORD_W = (WORD_K == 0) ? 1 : WORD_K;
   localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(WORDS_PER_BLOCK - 1);

   memctrl_state_t      state, state_nx;
   logic [WORD_W-1:0]   word, word_nx;
   logic [CPUID_W-1:0]  req, req_nx, sup, sup_nx;
   logic                rdx, rdx_nx;
   logic [CPUID_W-1:0]  ptr;
   logic [CPUS-1:0]     wr_req, rd_req, cls_req, grant;
   logic [CPUID_W-1:0]  grant_idx, snoop_sup;
   logic                snoop_hit, ram_done, last_word;
   logic [31:0]         blk_addr;

   assign wr_req    = dWEN;
   assign rd_req    = dREN & cctrans;
   assign cls_req   = (|wr_req) ? wr_req : ((|rd_req) ? rd_req : iREN);
   assign ram_done  = (ramstate == ACCESS);
   assign last_word = (word == LAST_WORD);
   assign blk_addr  = WORD_OFFSET(daddr[req], 32'(word), WORD_K);

`ifdef MEMCTRL_RR_ARB_EN
   logic txn_done;

   assign txn_done = ram_done &&
                     ((state == IFETCH) ||
                      (((state == C2C) || (state == RAMRD) || (state == RAMWR)) && last_word));

   // Next search starts just past the core that finished.
   always_ff @(posedge CLK) begin
      if (RST)           ptr <= '0;
      else if (txn_done) ptr <= (req == CPUID_W'(CPUS - 1)) ? '0 : req + CPUID_W'(1);
   end
`else
   assign ptr = '0;
`endif

   rr_arbiter #(.CPUS(CPUS), .CPUID_W(CPUID_W)) u_arb (
      .req   (cls_req),
      .ptr   (ptr),
      .grant (grant),
      .idx   (grant_idx)
   );

   // Lowest-index other core holding the block in M supplies it.
   always_comb begin
      snoop_hit = 1'b0;
      snoop_sup = '0;
      for (int unsigned i = 0; i < CPUS; i++) begin
         if (!snoop_hit && snoophit[CPUID_W'(i)] && (CPUID_W'(i) != req)) begin
            snoop_hit = 1'b1;
            snoop_sup = CPUID_W'(i);
         end
      end
   end

   always_comb begin
      state_nx = state;
      word_nx  = word;
      req_nx   = req;
      sup_nx   = sup;
      rdx_nx   = rdx;
      case (state)
         IDLE: begin
            word_nx = '0;
            if (|grant) begin
               req_nx   = grant_idx;
               rdx_nx   = ccwrite[grant_idx];
               state_nx = (|wr_req) ? RAMWR : ((|rd_req) ? SNOOP : IFETCH);
            end
         end
         SNOOP: begin
            sup_nx   = snoop_sup;
            state_nx = snoop_hit ? C2C : RAMRD;
         end
         C2C, RAMRD, RAMWR: begin
            if (ram_done) begin
               if (last_word) begin
                  word_nx  = '0;
                  state_nx = IDLE;
               end else begin
                  word_nx = word + WORD_W'(1);
               end
            end
         end
         IFETCH: begin
            if (ram_done) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= IDLE;
         word  <= '0;
         req   <= '0;
         sup   <= '0;
         rdx   <= 1'b0;
      end else begin
         state <= state_nx;
         word  <= word_nx;
         req   <= req_nx;
         sup   <= sup_nx;
         rdx   <= rdx_nx;
      end
   end

   // Bus outputs; forced to their idle values while RST is high.
   always_comb begin
      iwait       = '1;
      dwait       = '1;
      iload       = '0;
      dload       = '0;
      ccwait      = '0;
      ccinv       = '0;
      ccsnoopaddr = '0;
      ramREN      = 1'b0;
      ramWEN      = 1'b0;
      ramaddr     = '0;
      ramstore    = '0;
      if (!RST) begin
         case (state)
            SNOOP: begin
               for (int unsigned i = 0; i < CPUS; i++) begin
                  if (CPUID_W'(i) != req) begin
                     ccwait[CPUID_W'(i)]      = 1'b1;
                     ccinv[CPUID_W'(i)]       = rdx;
                     ccsnoopaddr[CPUID_W'(i)] = daddr[req];
                  end
               end
            end
            C2C: begin
               ccwait[sup]      = 1'b1;
               ccsnoopaddr[sup] = daddr[req];
               ramWEN           = 1'b1;
               ramaddr          = blk_addr;
               ramstore         = dstore[sup];
               dload[req]       = dstore[sup];
               if (ram_done) begin
                  dwait[req] = 1'b0;
                  dwait[sup] = 1'b0;
               end
            end
            RAMRD: begin
               for (int unsigned i = 0; i < CPUS; i++) begin
                  if (CPUID_W'(i) != req) ccsnoopaddr[CPUID_W'(i)] = daddr[req];
               end
               ramREN     = 1'b1;
               ramaddr    = blk_addr;
               dload[req] = ramload;
               if (ram_done) dwait[req] = 1'b0;
            end
            RAMWR: begin
               ramWEN   = 1'b1;
               ramaddr  = blk_addr;
               ramstore = dstore[req];
               if (ram_done) dwait[req] = 1'b0;
            end
            IFETCH: begin
               ramREN     = 1'b1;
               ramaddr    = iaddr[req];
               iload[req] = ramload;
               if (ram_done) iwait[req] = 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule
